// File: rtl/c17_bist_ctrl.sv
// BIST controller for the c17 netlist: 5-bit LFSR pattern source, 8-bit MISR
// response compactor, and a golden-signature compare at the end of each run.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start, pattern bus held at zero
// ST_RUN  | one pattern driven and captured per cycle
// ST_DONE | run complete, done/pass held until the next start
module c17_bist_ctrl #(
  parameter int unsigned PATTERN_COUNT = 32,
  parameter logic [4:0]  LFSR_SEED     = 5'h1F,
  parameter logic [7:0]  MISR_SEED     = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] golden_sig,
  output logic [4:0] pat_out,
  input  logic [1:0] resp_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
  localparam logic [4:0]  SEED_EFF = (LFSR_SEED == 5'h00) ? 5'h01 : LFSR_SEED;
  localparam logic [15:0] LAST_IDX = 16'(PATTERN_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  lfsr_q, lfsr_d;
  logic [7:0]  misr_q, misr_d;
  logic [15:0] count_q, count_d;
  logic        pass_q, pass_d;

  logic [4:0]  lfsr_step;
  logic [7:0]  misr_step;
  logic        misr_fb;

  assign lfsr_step = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
  assign misr_fb   = misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3];
  assign misr_step = {misr_q[6:0], misr_fb} ^ {6'b0, resp_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lfsr_q  <= SEED_EFF;
      misr_q  <= 8'h00;
      count_q <= 16'h0000;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      count_q <= count_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    count_d = count_q;
    pass_d  = pass_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          lfsr_d  = SEED_EFF;
          misr_d  = MISR_SEED;
          count_d = 16'h0000;
          pass_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (abort) begin
          // Partial signature is left visible; no capture this cycle.
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else begin
          lfsr_d = lfsr_step;
          misr_d = misr_step;
          if (count_q == LAST_IDX) begin
            state_d = ST_DONE;
            pass_d  = (misr_step == golden_sig);
          end else begin
            count_d = count_q + 16'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign pat_out   = busy ? lfsr_q : 5'h00;
  assign pass      = pass_q;
  assign signature = misr_q;

endmodule

// File: doc/c17_bist_ctrl.md
# c17_bist_ctrl

Built-in self-test controller that sits directly upstream and downstream of the c17 benchmark netlist. It drives the five primary inputs from a 5-bit LFSR pattern generator. It compacts the two primary outputs into an 8-bit MISR signature and compares the final signature against a golden value. Its purpose is oracle-style functional checking of original and locked c17 instances in the locking flow.

## Interface

**Parameters**

- `PATTERN_COUNT`, default 32: number of patterns applied per run. Legal range is 1..65535.
- `LFSR_SEED`, default 5'h1F: initial LFSR state. A value of 0 is replaced by 5'h01.
- `MISR_SEED`, default 8'h00: MISR value loaded at run start.

**Ports** (name, direction, width, meaning)

- `clk`, in, 1: the single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset. Asynchronous, active-low.
- `start`, in, 1: run request. Sampled in IDLE or DONE.
- `abort`, in, 1: synchronous cancel. Sampled in RUN.
- `golden_sig`, in, 8: expected signature.
- `pat_out`, out, 5: pattern to the c17 inputs. Bit mapping: [4]=N1, [3]=N2, [2]=N3, [1]=N6, [0]=N7.
- `resp_in`, in, 2: c17 response. Bit mapping: [0]=N22, [1]=N23. The netlist is combinational, so the response is valid in the same cycle as the pattern.
- `busy`, out, 1: high while in RUN.
- `done`, out, 1: high while in DONE.
- `pass`, out, 1: `signature == golden_sig`, registered on entry to DONE.
- `signature`, out, 8: current MISR value.

## Operation

**States:** IDLE, RUN, DONE.

**Transitions**

- IDLE, `start`=1: go to RUN. Load LFSR ← seed, MISR ← `MISR_SEED`, count ← 0, `pass` ← 0.
- RUN, every cycle: capture one pattern.
  - MISR ← next(MISR, `resp_in`).
  - LFSR ← next(LFSR).
  - count ← count+1.
  - If count == `PATTERN_COUNT`-1 at that edge, go to DONE and register `pass` using the updated MISR.
- RUN, `abort`=1: go to IDLE with no capture that cycle. `pass` ← 0. `signature` holds the partial value.
  - `abort` has priority over the terminal capture.
  - `start` is ignored in RUN.
- DONE: `done` and `pass` hold until `start`=1. Then reload and go to RUN, exactly as from IDLE. `abort` is ignored in DONE.

**Arithmetic**

- LFSR is a Fibonacci register, x^5+x^3+1: next = {lfsr[3:0], lfsr[4]^lfsr[2]}. The period is 31, so after 31 patterns it returns to the seed and wraps with no special handling.
- MISR feedback: fb = m[7]^m[5]^m[4]^m[3].
- MISR update: next = {m[6:0], fb} ^ {6'b0, resp_in[1:0]}.
- Pattern counter is 16 bits, unsigned. It never exceeds `PATTERN_COUNT`-1.

**Outputs**

- `pat_out` = LFSR while in RUN, 5'h00 otherwise.
- `busy` and `done` are decoded from the state register. They are never high together.

## Timing

- **Reset values** (immediate on `rst_n` low, independent of `clk`): state IDLE, LFSR = seed, MISR = 8'h00, count 0, `pat_out` 0, `busy` 0, `done` 0, `pass` 0, `signature` 8'h00.
- **Reset mid-run:** aborts with no partial result. `rst_n` deassertion is used as-is; no internal synchronizer.
- **Run latency:** `start` sampled at edge 0.
  - RUN occupies cycles 1..N, where N = `PATTERN_COUNT`. Pattern i is driven in cycle i+1 and captured at edge i+1.
  - `done`/`pass` are valid from cycle N+1.
  - Back-to-back runs: `start` held high in DONE re-enters RUN the next cycle.
- **Single-pattern run** (`PATTERN_COUNT`=1): RUN lasts exactly one cycle.
- **`start` and `abort` together in RUN:** abort wins and `start` is dropped. The controller is in IDLE the next cycle.

## Test plan

- **Reset:** assert `rst_n`=0 mid-cycle → all outputs 0 and state IDLE without a clock edge. Release, and hold `start`=0 for 10 cycles → outputs unchanged.
- **Single pattern:** `PATTERN_COUNT`=1, seed 5'h1F, real c17 attached, `golden_sig`=8'h01.
  - `pat_out`=5'b11111 for one cycle, with `resp_in`=2'b01.
  - Then `done`=1, `signature`=8'h01, `pass`=1, `busy`=0.
- **Two patterns:** `PATTERN_COUNT`=2, seed 5'h1F, `golden_sig`=8'h03.
  - `pat_out` sequence 5'h1F, 5'h1E.
  - Final `signature`=8'h03 and `pass`=1.
  - Same run with `resp_in` forced to 2'b00 → `signature`=8'h00 and `pass`=0.
- **LFSR wrap:** `PATTERN_COUNT`=32, seed 5'h1F.
  - 31 distinct nonzero patterns, then pattern 32 equals 5'h1F.
  - `busy` is high for exactly 32 cycles.
  - `LFSR_SEED`=0 produces 5'h01 as the first pattern.
- **Abort and restart:** `PATTERN_COUNT`=32.
  - `abort` at RUN cycle 5 → IDLE next cycle, `busy`=0, `done`=0, `pass`=0, `signature` holds the partial value.
  - A subsequent `start` yields the same final signature as an uninterrupted run.
- **Back-to-back:** hold `start`=1 continuously → `done` is high for exactly one cycle between consecutive RUN phases, and both runs give identical signatures.
